extram_bridge: RTL and testbench
================================

EXTRAM_BRIDGE -- requirements
Module: extram_bridge

Interface
REQ-001 The block SHALL have parameter NUM_SLAVES, default 3, giving the number of peripheral windows (2..8).
REQ-002 The block SHALL have parameter ADDR_W, default 16, giving the external-RAM address width.
REQ-003 The block SHALL have parameter SEL_LSB, default 11, giving the lowest address bit of the slave-select field; the field width is SEL_W = clog2(NUM_SLAVES).
REQ-004 The block SHALL have parameter STROBE_CYCLES, default 2, giving the minimum number of clk cycles slv_cs is asserted (1..15).
REQ-005 The block SHALL have parameter TIMEOUT, default 255, giving the maximum number of clk cycles spent in WAIT (1..65535).
REQ-006 The block SHALL have port clk, input, width 1: single clock for all logic.
REQ-007 The block SHALL have port reset_, input, width 1: asynchronous, active-low reset.
REQ-008 The block SHALL have ports cpu_a / cpu_d_out / cpu_cs / cpu_oe / cpu_we, inputs, widths ADDR_W/8/1/1/1: CPU-side request.
REQ-009 The block SHALL have ports cpu_d_in (output, width 8, registered read data) and cpu_ready (output, width 1, completion pulse).
REQ-010 The block SHALL have ports slv_a (output, ADDR_W), slv_d_out (output, 8), slv_oe (output, 1), slv_we (output, 1) and slv_cs (output, NUM_SLAVES): shared peripheral bus plus one-hot select.
REQ-011 The block SHALL have ports slv_d_in (input, 8*NUM_SLAVES, slave i on bits 8i+7:8i) and slv_wait (input, NUM_SLAVES).
REQ-012 The block SHALL have ports slv_irq (input, NUM_SLAVES, asynchronous), irq_ack (input, NUM_SLAVES), irq_pending (output, NUM_SLAVES) and irq_out (output, 1).
REQ-013 The block SHALL have port bus_err (output, 1): sticky flag for timeout or unmapped access.

Function
REQ-014 The FSM SHALL have the states IDLE, SETUP, STROBE, WAIT, DONE and HOLD.
REQ-015 In IDLE, when cpu_cs=1 is sampled, the FSM SHALL latch cpu_a, cpu_d_out, cpu_oe and cpu_we, compute idx = cpu_a[SEL_LSB+SEL_W-1:SEL_LSB], and go to SETUP.
REQ-016 In SETUP (one cycle), slv_a, slv_d_out, slv_oe and slv_we SHALL be driven from the latched values with all slv_cs=0; next state is STROBE, or DONE if idx >= NUM_SLAVES.
REQ-017 In STROBE, slv_cs[idx] SHALL be 1 for exactly STROBE_CYCLES cycles; other slv_cs bits SHALL stay 0.
REQ-018 On the last STROBE cycle, if slv_wait[idx]=0 the block SHALL capture slave idx's byte of slv_d_in into cpu_d_in (reads only) and go to DONE; otherwise it SHALL go to WAIT.
REQ-019 In WAIT, slv_cs[idx] SHALL be held at 1, and the block SHALL capture data and go to DONE on the first cycle slv_wait[idx]=0.
REQ-020 A 16-bit WAIT counter SHALL abort the access when it reaches TIMEOUT: slv_cs drops, cpu_d_in=8'hFF, bus_err=1, next state DONE.
REQ-021 An unmapped idx SHALL set cpu_d_in=8'hFF and bus_err=1, with no slv_cs asserted.
REQ-022 A write SHALL leave cpu_d_in unchanged.
REQ-023 In DONE, cpu_ready SHALL be 1 for exactly one cycle; next state is HOLD if cpu_cs=1, otherwise IDLE.
REQ-024 HOLD SHALL return to IDLE only when cpu_cs=0 (no retrigger while cpu_cs is held high).
REQ-025 Deasserting cpu_cs mid-access SHALL NOT abort the access; it completes normally.
REQ-026 Latency: with no wait states, cpu_ready SHALL assert STROBE_CYCLES+2 cycles after the cycle cpu_cs is sampled in IDLE.
REQ-027 Each slv_irq bit SHALL pass through a 2-flop synchronizer; a synchronized rising edge SHALL set irq_pending[i].
REQ-028 irq_ack[i]=1 SHALL clear irq_pending[i]; if a set and an ack occur in the same cycle, set SHALL win.
REQ-029 irq_out SHALL be registered as the OR of irq_pending.
REQ-030 bus_err SHALL be cleared only by reset.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 Asserting reset_ low SHALL immediately force: FSM=IDLE, all slv_cs=0, slv_oe=0, slv_we=0, slv_a=0, slv_d_out=0, cpu_d_in=0, cpu_ready=0, irq_pending=0, irq_out=0, bus_err=0, synchronizers=0, counters=0.
REQ-033 Reset asserted mid-access SHALL abandon the access with no cpu_ready pulse.
REQ-034 After reset_ rises, the first access SHALL be accepted on the next clk edge with cpu_cs=1.

Verification
REQ-035 Read, no wait: cpu_a=16'h1000, slv_d_in slave 2 byte=8'hA5, STROBE_CYCLES=2 -> slv_cs=3'b100 for 2 cycles, cpu_ready at +4, cpu_d_in=8'hA5.
REQ-036 Write with wait: cpu_a=16'h0800, cpu_d_out=8'h3C, slv_wait[1] high 5 cycles -> slv_cs[1] high 7 cycles total, slv_we=1, slv_d_out=8'h3C, single cpu_ready pulse.
REQ-037 Timeout: TIMEOUT=8, slv_wait[0] stuck high -> slv_cs[0] drops after 8 WAIT cycles, cpu_d_in=8'hFF, bus_err=1, cpu_ready pulse.
REQ-038 Unmapped: NUM_SLAVES=3, cpu_a=16'h1800 -> no slv_cs, cpu_d_in=8'hFF, bus_err=1, cpu_ready at +2.
REQ-039 IRQ: slv_irq[2] rising -> irq_pending=3'b100 within 3 cycles, then irq_out; irq_ack[2] in the same cycle as a new edge -> pending stays 1.
REQ-040 Reset during WAIT -> all slv_cs=0 at once, no cpu_ready pulse, next access completes normally.

Source files
------------

// File: rtl/extram_bridge.sv
// CPU to external-RAM peripheral bridge: decodes a slave window from the address,
// runs a setup/strobe/wait handshake on a shared bus and synchronises slave IRQs.
module extram_bridge #(
  parameter int unsigned NUM_SLAVES    = 3,
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned SEL_LSB       = 11,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic                    clk,
  input  logic                    reset_,
  input  logic [ADDR_W-1:0]       cpu_a,
  input  logic [7:0]              cpu_d_out,
  input  logic                    cpu_cs,
  input  logic                    cpu_oe,
  input  logic                    cpu_we,
  output logic [7:0]              cpu_d_in,
  output logic                    cpu_ready,
  output logic [ADDR_W-1:0]       slv_a,
  output logic [7:0]              slv_d_out,
  output logic                    slv_oe,
  output logic                    slv_we,
  output logic [NUM_SLAVES-1:0]   slv_cs,
  input  logic [8*NUM_SLAVES-1:0] slv_d_in,
  input  logic [NUM_SLAVES-1:0]   slv_wait,
  input  logic [NUM_SLAVES-1:0]   slv_irq,
  input  logic [NUM_SLAVES-1:0]   irq_ack,
  output logic [NUM_SLAVES-1:0]   irq_pending,
  output logic                    irq_out,
  output logic                    bus_err
);

  localparam int unsigned SEL_W = $clog2(NUM_SLAVES);
  localparam logic [SEL_W:0] NUM_S  = (SEL_W+1)'(NUM_SLAVES);
  localparam logic [3:0]     STB_M1 = 4'(STROBE_CYCLES - 1);
  localparam logic [15:0]    TO_M1  = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT, DONE, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [SEL_W-1:0]        idx_q, idx_d;
  logic [ADDR_W-1:0]       slv_a_q, slv_a_d;
  logic [7:0]              slv_d_out_q, slv_d_out_d;
  logic                    slv_oe_q, slv_oe_d;
  logic                    slv_we_q, slv_we_d;
  logic [NUM_SLAVES-1:0]   slv_cs_q, slv_cs_d;
  logic [3:0]              strb_cnt_q, strb_cnt_d;
  logic [15:0]             wait_cnt_q, wait_cnt_d;
  logic [7:0]              cpu_d_in_q, cpu_d_in_d;
  logic                    cpu_ready_q, cpu_ready_d;
  logic                    bus_err_q, bus_err_d;
  logic [NUM_SLAVES-1:0]   sync1_q, sync2_q, sync3_q;
  logic [NUM_SLAVES-1:0]   irq_pend_q, irq_pend_d;
  logic                    irq_out_q;

  logic [NUM_SLAVES-1:0]   sel_onehot;
  logic [7:0]              rd_byte;
  logic                    wait_sel;
  logic                    unmapped;
  logic                    fin_ok, fin_err;

  always_comb begin
    sel_onehot = '0;
    rd_byte    = '0;
    wait_sel   = 1'b0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == i[SEL_W-1:0]) begin
        sel_onehot[i] = 1'b1;
        rd_byte       = slv_d_in[8*i +: 8];
        wait_sel      = slv_wait[i];
      end
    end
  end

  assign unmapped = ({1'b0, idx_q} >= NUM_S);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    slv_a_d     = slv_a_q;
    slv_d_out_d = slv_d_out_q;
    slv_oe_d    = slv_oe_q;
    slv_we_d    = slv_we_q;
    slv_cs_d    = slv_cs_q;
    strb_cnt_d  = strb_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    cpu_d_in_d  = cpu_d_in_q;
    cpu_ready_d = 1'b0;
    bus_err_d   = bus_err_q;
    fin_ok      = 1'b0;
    fin_err     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cpu_cs) begin
          slv_a_d     = cpu_a;
          slv_d_out_d = cpu_d_out;
          slv_oe_d    = cpu_oe;
          slv_we_d    = cpu_we;
          idx_d       = cpu_a[SEL_LSB +: SEL_W];
          state_d     = SETUP;
        end
      end
      SETUP: begin
        strb_cnt_d = '0;
        wait_cnt_d = '0;
        if (unmapped) begin
          fin_err = 1'b1;
        end else begin
          slv_cs_d = sel_onehot;
          state_d  = STROBE;
        end
      end
      STROBE: begin
        if (strb_cnt_q == STB_M1) begin
          if (!wait_sel) fin_ok = 1'b1;
          else           state_d = WAIT;
        end else begin
          strb_cnt_d = strb_cnt_q + 4'd1;
        end
      end
      WAIT: begin
        if (!wait_sel)                fin_ok = 1'b1;
        else if (wait_cnt_q == TO_M1) fin_err = 1'b1;
        else                          wait_cnt_d = wait_cnt_q + 16'd1;
      end
      DONE: begin
        state_d = cpu_cs ? HOLD : IDLE;
      end
      HOLD: begin
        if (!cpu_cs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Completion is shared by normal, timeout and unmapped paths; errors force 8'hFF
    // even on writes so the CPU always sees a defined error byte.
    if (fin_ok || fin_err) begin
      state_d     = DONE;
      cpu_ready_d = 1'b1;
      slv_cs_d    = '0;
      slv_oe_d    = 1'b0;
      slv_we_d    = 1'b0;
      strb_cnt_d  = '0;
      wait_cnt_d  = '0;
      if (fin_err) begin
        cpu_d_in_d = 8'hFF;
        bus_err_d  = 1'b1;
      end else if (slv_oe_q) begin
        cpu_d_in_d = rd_byte;
      end
    end
  end

  // Set beats ack when a fresh synchronised edge coincides with irq_ack.
  assign irq_pend_d = (irq_pend_q & ~irq_ack) | (sync2_q & ~sync3_q);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      slv_a_q     <= '0;
      slv_d_out_q <= '0;
      slv_oe_q    <= 1'b0;
      slv_we_q    <= 1'b0;
      slv_cs_q    <= '0;
      strb_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      cpu_d_in_q  <= '0;
      cpu_ready_q <= 1'b0;
      bus_err_q   <= 1'b0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync3_q     <= '0;
      irq_pend_q  <= '0;
      irq_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      slv_a_q     <= slv_a_d;
      slv_d_out_q <= slv_d_out_d;
      slv_oe_q    <= slv_oe_d;
      slv_we_q    <= slv_we_d;
      slv_cs_q    <= slv_cs_d;
      strb_cnt_q  <= strb_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      cpu_d_in_q  <= cpu_d_in_d;
      cpu_ready_q <= cpu_ready_d;
      bus_err_q   <= bus_err_d;
      sync1_q     <= slv_irq;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      irq_pend_q  <= irq_pend_d;
      irq_out_q   <= |irq_pend_q;
    end
  end

  assign cpu_d_in    = cpu_d_in_q;
  assign cpu_ready   = cpu_ready_q;
  assign slv_a       = slv_a_q;
  assign slv_d_out   = slv_d_out_q;
  assign slv_oe      = slv_oe_q;
  assign slv_we      = slv_we_q;
  assign slv_cs      = slv_cs_q;
  assign bus_err     = bus_err_q;
  assign irq_pending = irq_pend_q;
  assign irq_out     = irq_out_q;

endmodule

// File: tb/tb_extram_bridge.sv
// Scoreboard bench for extram_bridge: accesses push expectations, the ready monitor
// pops and compares data, error flag, select pattern, strobe length and latency.
module tb_extram_bridge;

  localparam int NS = 3;
  localparam int SC = 2;
  localparam int TO = 8;

  logic            clk;
  logic            reset_;
  logic [15:0]     cpu_a;
  logic [7:0]      cpu_d_out;
  logic            cpu_cs, cpu_oe, cpu_we;
  logic [7:0]      cpu_d_in;
  logic            cpu_ready;
  logic [15:0]     slv_a;
  logic [7:0]      slv_d_out;
  logic            slv_oe, slv_we;
  logic [NS-1:0]   slv_cs;
  logic [8*NS-1:0] slv_d_in;
  logic [NS-1:0]   slv_wait;
  logic [NS-1:0]   slv_irq, irq_ack, irq_pending;
  logic            irq_out, bus_err;

  extram_bridge #(
    .NUM_SLAVES(NS), .ADDR_W(16), .SEL_LSB(11), .STROBE_CYCLES(SC), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_(reset_),
    .cpu_a(cpu_a), .cpu_d_out(cpu_d_out), .cpu_cs(cpu_cs), .cpu_oe(cpu_oe), .cpu_we(cpu_we),
    .cpu_d_in(cpu_d_in), .cpu_ready(cpu_ready),
    .slv_a(slv_a), .slv_d_out(slv_d_out), .slv_oe(slv_oe), .slv_we(slv_we), .slv_cs(slv_cs),
    .slv_d_in(slv_d_in), .slv_wait(slv_wait),
    .slv_irq(slv_irq), .irq_ack(irq_ack), .irq_pending(irq_pending), .irq_out(irq_out),
    .bus_err(bus_err)
  );

  typedef struct {
    logic [15:0] a;
    logic        we;
    logic [7:0]  wd;
    logic [7:0]  d;
    logic [2:0]  cs;
    int          len;
    int          lat;
    logic        err;
    int          t0;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   wait_len = 0;
  logic [NS-1:0] stuck = '0;
  logic [7:0] last_rd = 8'h00;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Slave model: raises wait one cycle after select and holds it for wait_len cycles.
  initial begin
    int seen [NS];
    for (int i = 0; i < NS; i++) seen[i] = 0;
    slv_wait = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NS; i++) begin
        if (slv_cs[i]) seen[i]++;
        else           seen[i] = 0;
        slv_wait[i] = stuck[i] | (seen[i] >= 2 && seen[i] <= wait_len + 1);
      end
    end
  end

  // Completion monitor
  initial begin
    int          cs_len;
    logic [2:0]  cs_seen;
    logic [15:0] cap_a;
    logic        cap_we, cap_oe;
    logic [7:0]  cap_do;
    exp_t        e;
    cs_len = 0; cs_seen = '0; cap_a = '0; cap_we = 0; cap_oe = 0; cap_do = '0;
    forever begin
      @(negedge clk);
      if (!reset_) begin
        cs_len = 0;
        cs_seen = '0;
      end else begin
        if (slv_cs != '0) begin
          if (cs_len == 0) begin
            cap_a = slv_a; cap_we = slv_we; cap_oe = slv_oe; cap_do = slv_d_out;
          end
          cs_len++;
          cs_seen |= slv_cs;
        end
        if (cpu_ready) begin
          if (sb.size() == 0) begin
            check("spurious_ready", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("rd_data", cpu_d_in, e.d);
            check("bus_err", bus_err, e.err);
            check("cs_pattern", cs_seen, e.cs);
            check("cs_len", cs_len, e.len);
            check("latency", cyc - e.t0, e.lat);
            if (e.cs != '0) begin
              check("slv_a", cap_a, e.a);
              check("slv_we", cap_we, e.we);
              check("slv_oe", cap_oe, !e.we);
              if (e.we) check("slv_d_out", cap_do, e.wd);
            end
          end
          cs_len = 0;
          cs_seen = '0;
          done_cnt++;
        end
      end
    end
  end

  // Caller is at a negedge; returns at a negedge with cpu_cs low.
  task automatic do_access(input logic [15:0] a, input logic we, input logic [7:0] wd,
                           input int wl, input bit drop_early, input logic [7:0] exp_d,
                           input logic [2:0] exp_cs, input int exp_len, input logic exp_err);
    exp_t e;
    int   start_done, budget;
    wait_len = wl;
    e.a = a; e.we = we; e.wd = wd; e.d = exp_d; e.cs = exp_cs; e.len = exp_len;
    e.lat = exp_len + 2; e.err = exp_err; e.t0 = cyc;
    sb.push_back(e);
    start_done = done_cnt;
    cpu_a = a; cpu_d_out = wd; cpu_we = we; cpu_oe = !we; cpu_cs = 1'b1;
    budget = 0;
    while (done_cnt == start_done && budget < 100) begin
      @(negedge clk);
      budget++;
      if (drop_early) cpu_cs = 1'b0;
    end
    if (done_cnt == start_done) check("ready_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
    cpu_cs = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int saved, budget;
    reset_ = 1'b0;
    cpu_a = '0; cpu_d_out = '0; cpu_cs = 0; cpu_oe = 0; cpu_we = 0;
    slv_d_in = '0; slv_irq = '0; irq_ack = '0;
    repeat (3) @(negedge clk);
    check("rst_slv_cs", slv_cs, 0);
    check("rst_ready", cpu_ready, 0);
    check("rst_d_in", cpu_d_in, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_slv_a", slv_a, 0);
    check("rst_oe_we", {slv_oe, slv_we}, 0);
    check("rst_irq", {irq_out, irq_pending}, 0);
    reset_ = 1'b1;
    @(negedge clk);

    slv_d_in[23:16] = 8'hA5;
    do_access(16'h1000, 0, 8'h00, 0, 0, 8'hA5, 3'b100, SC, 0); last_rd = 8'hA5;
    slv_d_in[7:0] = 8'h5A;
    do_access(16'h0000, 0, 8'h00, 0, 0, 8'h5A, 3'b001, SC, 0); last_rd = 8'h5A;
    do_access(16'h0800, 1, 8'h3C, 5, 0, last_rd, 3'b010, 7, 0);
    slv_d_in[15:8] = 8'hC3;
    do_access(16'h0FFF, 0, 8'h00, 3, 1, 8'hC3, 3'b010, 5, 0); last_rd = 8'hC3;
    slv_d_in[23:16] = 8'h96;
    do_access(16'h1234, 0, 8'h00, 0, 0, 8'h96, 3'b100, SC, 0);
    do_access(16'h1800, 0, 8'h00, 0, 0, 8'hFF, 3'b000, 0, 1);
    slv_d_in[23:16] = 8'h11;
    do_access(16'h1000, 0, 8'h00, 0, 0, 8'h11, 3'b100, SC, 1);

    // Reset while the access is stretched in WAIT
    stuck[1] = 1'b1;
    cpu_a = 16'h0800; cpu_oe = 1; cpu_we = 0; cpu_cs = 1;
    budget = 0;
    while (!slv_cs[1] && budget < 20) begin @(negedge clk); budget++; end
    check("wait_entry_cs", slv_cs[1], 1);
    repeat (3) @(negedge clk);
    saved = done_cnt;
    #2 reset_ = 1'b0;
    #1;
    check("rst_mid_cs", slv_cs, 0);
    check("rst_mid_ready", cpu_ready, 0);
    check("rst_mid_err", bus_err, 0);
    check("rst_mid_oe", slv_oe, 0);
    cpu_cs = 0; stuck = '0;
    repeat (3) @(negedge clk);
    check("rst_no_ready", done_cnt, saved);
    reset_ = 1'b1;
    slv_d_in[7:0] = 8'h77;
    do_access(16'h0000, 0, 8'h00, 0, 0, 8'h77, 3'b001, SC, 0);

    stuck[0] = 1'b1;
    do_access(16'h0000, 0, 8'h00, 0, 0, 8'hFF, 3'b001, SC + TO, 1);
    stuck = '0;
    check("no_extra_ready", sb.size(), 0);

    // IRQ synchroniser, pending, ack and set-beats-ack
    slv_irq[2] = 1'b1;
    repeat (2) @(negedge clk);
    check("irq_not_yet", irq_pending, 3'b000);
    @(negedge clk);
    check("irq_pending", irq_pending, 3'b100);
    check("irq_out_lag", irq_out, 0);
    @(negedge clk);
    check("irq_out", irq_out, 1);
    slv_irq[2] = 1'b0;
    repeat (4) @(negedge clk);
    check("irq_held", irq_pending, 3'b100);
    slv_irq[2] = 1'b1;
    repeat (2) @(negedge clk);
    irq_ack[2] = 1'b1;
    @(negedge clk);
    irq_ack[2] = 1'b0;
    check("irq_set_wins", irq_pending, 3'b100);
    irq_ack[2] = 1'b1;
    @(negedge clk);
    irq_ack[2] = 1'b0;
    check("irq_ack_clear", irq_pending, 3'b000);
    @(negedge clk);
    check("irq_out_clear", irq_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
